// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use and branch hazard unit beside the decode stage.
// Tracks in-flight register writers issued from ID, counts down the cycles
// until each result can be forwarded, and stalls the ID instruction for as
// long as an EX-stage consumer or an ID-resolved branch still has to wait.
module hazard_scoreboard #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int BRANCH_IN_ID    = 1,
    parameter int ENTRIES         = LOAD_USE_CYCLES + 2,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_is_branch,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  flush,
    output logic                  pc_write,
    output logic                  IF_ID_write,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count,
    output logic                  overflow
);

    // Waits never exceed LOAD_USE_CYCLES + BRANCH_IN_ID (at most 7).
    localparam int WAIT_W = 3;

    localparam logic [WAIT_W-1:0]     WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]     WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0]     LOAD_EX   = WAIT_W'(LOAD_USE_CYCLES);
    localparam logic [WAIT_W-1:0]     LOAD_ID   = WAIT_W'(LOAD_USE_CYCLES + BRANCH_IN_ID);
    localparam logic [WAIT_W-1:0]     ALU_ID    = WAIT_W'(BRANCH_IN_ID);
    localparam logic                  BR_IN_ID  = 1'(BRANCH_IN_ID);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};

    // Scoreboard state
    logic [ENTRIES-1:0]    valid_r;
    logic [REG_ADDR_W-1:0] dest_r    [ENTRIES];
    logic [WAIT_W-1:0]     wait_ex_r [ENTRIES];
    logic [WAIT_W-1:0]     wait_id_r [ENTRIES];
    logic [CNT_W-1:0]      stall_count_r;
    logic                  overflow_r;

    // Combinational helpers
    logic [WAIT_W-1:0]     need_s    [ENTRIES];
    logic                  branch_mode_s;
    logic                  rs_hit_s;
    logic                  rt_hit_s;
    logic                  stall_s;
    logic                  issue_s;
    logic                  write_s;
    logic                  insert_s;
    logic [WAIT_W-1:0]     ins_ex_s;
    logic [WAIT_W-1:0]     ins_id_s;
    logic [ENTRIES-1:0]    nxt_valid_s;
    logic [REG_ADDR_W-1:0] nxt_dest_s    [ENTRIES];
    logic [WAIT_W-1:0]     nxt_wait_ex_s [ENTRIES];
    logic [WAIT_W-1:0]     nxt_wait_id_s [ENTRIES];
    logic                  slot_found_s;
    logic                  ovf_set_s;

    // Branches resolved in ID look at wait_id; everything else at wait_ex.
    assign branch_mode_s = id_is_branch & BR_IN_ID;

    // Per-source hazard detection; rs and rt hitting one entry is one hazard.
    always_comb begin
        rs_hit_s = 1'b0;
        rt_hit_s = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (branch_mode_s) begin
                need_s[i] = wait_id_r[i];
            end else begin
                need_s[i] = wait_ex_r[i];
            end
            if (valid_r[i] && (need_s[i] != WAIT_ZERO)) begin
                if (id_use_rs && (id_rs != REG_ZERO) && (dest_r[i] == id_rs)) begin
                    rs_hit_s = 1'b1;
                end else begin
                    rs_hit_s = rs_hit_s;
                end
                if (id_use_rt && (id_rt != REG_ZERO) && (dest_r[i] == id_rt)) begin
                    rt_hit_s = 1'b1;
                end else begin
                    rt_hit_s = rt_hit_s;
                end
            end else begin
                rs_hit_s = rs_hit_s;
                rt_hit_s = rt_hit_s;
            end
        end
    end

    assign stall_s  = id_valid & ~flush & (rs_hit_s | rt_hit_s);
    assign issue_s  = id_valid & ~flush & ~stall_s;
    assign write_s  = issue_s & id_reg_write & (id_dest != REG_ZERO);
    assign insert_s = write_s & ((ins_ex_s != WAIT_ZERO) | (ins_id_s != WAIT_ZERO));

    // Countdown values loaded for a freshly issued writer.
    always_comb begin
        if (id_mem_read) begin
            ins_ex_s = LOAD_EX;
            ins_id_s = LOAD_ID;
        end else begin
            ins_ex_s = WAIT_ZERO;
            ins_id_s = ALU_ID;
        end
    end

    // Next scoreboard: decrement, retire expired, kill older same-dest, insert lowest free.
    always_comb begin
        slot_found_s = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (wait_ex_r[i] != WAIT_ZERO) begin
                nxt_wait_ex_s[i] = wait_ex_r[i] - WAIT_ONE;
            end else begin
                nxt_wait_ex_s[i] = WAIT_ZERO;
            end
            if (wait_id_r[i] != WAIT_ZERO) begin
                nxt_wait_id_s[i] = wait_id_r[i] - WAIT_ONE;
            end else begin
                nxt_wait_id_s[i] = WAIT_ZERO;
            end
            nxt_dest_s[i] = dest_r[i];
            // A new writer of the same register supersedes this entry even when
            // the new writer itself needs no tracking.
            if (valid_r[i]
                && ((nxt_wait_ex_s[i] != WAIT_ZERO) || (nxt_wait_id_s[i] != WAIT_ZERO))
                && !(write_s && (dest_r[i] == id_dest))) begin
                nxt_valid_s[i] = 1'b1;
            end else begin
                nxt_valid_s[i] = 1'b0;
            end
            if (insert_s && !slot_found_s && !nxt_valid_s[i]) begin
                nxt_valid_s[i]   = 1'b1;
                nxt_dest_s[i]    = id_dest;
                nxt_wait_ex_s[i] = ins_ex_s;
                nxt_wait_id_s[i] = ins_id_s;
                slot_found_s     = 1'b1;
            end else begin
                slot_found_s = slot_found_s;
            end
        end
        ovf_set_s = insert_s & ~slot_found_s;
    end

    // Scoreboard registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                dest_r[i]    <= REG_ZERO;
                wait_ex_r[i] <= WAIT_ZERO;
                wait_id_r[i] <= WAIT_ZERO;
            end
        end else begin
            valid_r <= nxt_valid_s;
            for (int i = 0; i < ENTRIES; i++) begin
                dest_r[i]    <= nxt_dest_s[i];
                wait_ex_r[i] <= nxt_wait_ex_s[i];
                wait_id_r[i] <= nxt_wait_id_s[i];
            end
        end
    end

    // Saturating stall counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_count_r <= CNT_ZERO;
            overflow_r    <= 1'b0;
        end else begin
            if (stall_s && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
            overflow_r <= overflow_r | ovf_set_s;
        end
    end

    // Stall must act in the same cycle the hazard is seen, so it stays combinational.
    assign stall       = stall_s;
    assign pc_write    = ~stall_s;
    assign IF_ID_write = ~stall_s;
    assign stall_count = stall_count_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Four instances share one ID stream:
//   a: LOAD_USE_CYCLES=1, BRANCH_IN_ID=1 (defaults)
//   b: LOAD_USE_CYCLES=1, BRANCH_IN_ID=0
//   c: LOAD_USE_CYCLES=3, BRANCH_IN_ID=1, CNT_W=2 (counter saturates at 3)
//   d: LOAD_USE_CYCLES=1, BRANCH_IN_ID=1, ENTRIES=1 (overflow reachable)
// Expected results are queued as each step is driven and popped on the
// falling edge of that cycle.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rstn;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_branch;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [4:0] id_dest;
    logic       flush;

    logic stall_a, pcw_a, ifid_a, ovf_a;
    logic stall_b, pcw_b, ifid_b, ovf_b;
    logic stall_c, pcw_c, ifid_c, ovf_c;
    logic stall_d, pcw_d, ifid_d, ovf_d;
    logic [15:0] cnt_a, cnt_b, cnt_d;
    logic [1:0]  cnt_c;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string tag;
        int    dut;
        logic  stall;
        int    cnt;
        int    ovf;
    } exp_t;

    exp_t exp_q[$];

    hazard_scoreboard u_a (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .flush(flush), .pc_write(pcw_a), .IF_ID_write(ifid_a), .stall(stall_a),
        .stall_count(cnt_a), .overflow(ovf_a));

    hazard_scoreboard #(.BRANCH_IN_ID(0)) u_b (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .flush(flush), .pc_write(pcw_b), .IF_ID_write(ifid_b), .stall(stall_b),
        .stall_count(cnt_b), .overflow(ovf_b));

    hazard_scoreboard #(.LOAD_USE_CYCLES(3), .CNT_W(2)) u_c (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .flush(flush), .pc_write(pcw_c), .IF_ID_write(ifid_c), .stall(stall_c),
        .stall_count(cnt_c), .overflow(ovf_c));

    hazard_scoreboard #(.ENTRIES(1)) u_d (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .flush(flush), .pc_write(pcw_d), .IF_ID_write(ifid_d), .stall(stall_d),
        .stall_count(cnt_d), .overflow(ovf_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one expectation: stall level, and optionally count / overflow (-1 skips).
    task automatic ex(input string tag, input int dut, input logic s,
                      input int c = -1, input int o = -1);
        exp_t e;
        e.tag = tag; e.dut = dut; e.stall = s; e.cnt = c; e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic compare_one(input exp_t e);
        logic s, pw, iw, ov;
        logic [15:0] c;
        case (e.dut)
            0:       begin s = stall_a; pw = pcw_a; iw = ifid_a; ov = ovf_a; c = cnt_a; end
            1:       begin s = stall_b; pw = pcw_b; iw = ifid_b; ov = ovf_b; c = cnt_b; end
            2:       begin s = stall_c; pw = pcw_c; iw = ifid_c; ov = ovf_c; c = {14'd0, cnt_c}; end
            default: begin s = stall_d; pw = pcw_d; iw = ifid_d; ov = ovf_d; c = cnt_d; end
        endcase
        vectors++;
        assert (s === e.stall) else begin
            miscompares++;
            $error("FAIL %s[%0d].stall observed=%b expected=%b", e.tag, e.dut, s, e.stall);
        end
        vectors++;
        assert (pw === ~e.stall) else begin
            miscompares++;
            $error("FAIL %s[%0d].pc_write observed=%b expected=%b", e.tag, e.dut, pw, ~e.stall);
        end
        vectors++;
        assert (iw === ~e.stall) else begin
            miscompares++;
            $error("FAIL %s[%0d].IF_ID_write observed=%b expected=%b", e.tag, e.dut, iw, ~e.stall);
        end
        if (e.cnt >= 0) begin
            vectors++;
            assert (c === 16'(e.cnt)) else begin
                miscompares++;
                $error("FAIL %s[%0d].stall_count observed=%0d expected=%0d", e.tag, e.dut, c, e.cnt);
            end
        end
        if (e.ovf >= 0) begin
            vectors++;
            assert (ov === e.ovf[0]) else begin
                miscompares++;
                $error("FAIL %s[%0d].overflow observed=%b expected=%b", e.tag, e.dut, ov, e.ovf[0]);
            end
        end
    endtask

    task automatic chk_now();
        while (exp_q.size() > 0) compare_one(exp_q.pop_front());
    endtask

    // Compare this cycle on the falling edge, then move just past the next rising edge.
    task automatic chk();
        @(negedge clk);
        chk_now();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic br,
                         input logic rw, input logic mr, input logic [4:0] dest);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_is_branch = br; id_reg_write = rw; id_mem_read = mr; id_dest = dest;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic lw(input logic [4:0] dest, input logic [4:0] rs);
        drive(1'b1, rs, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, dest);
    endtask

    task automatic alu(input logic [4:0] dest, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt);
        drive(1'b1, rs, rt, 1'b1, urt, 1'b0, 1'b1, 1'b0, dest);
    endtask

    task automatic br(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        flush = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) ex("reset", k, 1'b0, 0, 0);
        chk_now();
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        flush = 1'b0;
        idle();
        #3;
        for (int k = 0; k < 4; k++) ex("in_reset", k, 1'b0, 0, 0);
        chk_now();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) ex("post_reset", k, 1'b0, 0, 0);
        chk();

        // lw $8 -> add rs=8: one bubble in both branch modes
        lw(5'd8, 5'd1);            ex("s1_lw", 0, 1'b0, 0); ex("s1_lw", 1, 1'b0, 0); chk();
        alu(5'd10, 5'd8, 5'd0, 1'b0);
                                   ex("s1_add", 0, 1'b1, 0); ex("s1_add", 1, 1'b1, 0); chk();
                                   ex("s1_go", 0, 1'b0, 1); ex("s1_go", 1, 1'b0, 1); chk();
        idle();                    ex("s1_idle", 0, 1'b0, 1); chk();

        // lw $8 -> beq rs=8: two bubbles with ID branches, one with EX branches
        do_reset();
        lw(5'd8, 5'd1);            ex("s2_lw", 0, 1'b0, 0); ex("s2_lw", 1, 1'b0, 0); chk();
        br(5'd8, 5'd0);            ex("s2_beq1", 0, 1'b1, 0); ex("s2_beq1", 1, 1'b1, 0); chk();
                                   ex("s2_beq2", 0, 1'b1, 1); ex("s2_beq2", 1, 1'b0, 1); chk();
                                   ex("s2_beq3", 0, 1'b0, 2); ex("s2_beq3", 1, 1'b0, 1); chk();
        idle();                    chk();

        // ALU producer: EX consumer never waits, ID branch waits one cycle
        do_reset();
        alu(5'd9, 5'd1, 5'd2, 1'b1); ex("s3_add", 0, 1'b0); ex("s3_add", 1, 1'b0); chk();
        alu(5'd10, 5'd1, 5'd9, 1'b1); ex("s3_sub", 0, 1'b0); ex("s3_sub", 1, 1'b0); chk();
        alu(5'd9, 5'd1, 5'd2, 1'b1); ex("s3_add2", 0, 1'b0); chk();
        br(5'd1, 5'd9);            ex("s3_beq1", 0, 1'b1, 0); ex("s3_beq1", 1, 1'b0, 0); chk();
                                   ex("s3_beq2", 0, 1'b0, 1); ex("s3_beq2", 1, 1'b0, 0); chk();
        idle();                    chk();

        // $0 never hazards; unused sources never hazard
        do_reset();
        lw(5'd0, 5'd1);            ex("s4_lw0", 0, 1'b0); chk();
        alu(5'd10, 5'd0, 5'd0, 1'b1); ex("s4_use0", 0, 1'b0); chk();
        lw(5'd8, 5'd1);            ex("s4_lw8", 0, 1'b0); chk();
        alu(5'd10, 5'd3, 5'd8, 1'b0); ex("s4_rt_unused", 0, 1'b0); ex("s4_rt_unused", 1, 1'b0); chk();
        idle();                    chk();

        // Newest writer wins; flushed instruction neither stalls nor inserts
        do_reset();
        lw(5'd8, 5'd1);            ex("s5_lw", 0, 1'b0); ex("s5_lw", 2, 1'b0); chk();
        alu(5'd8, 5'd1, 5'd0, 1'b0); ex("s5_addi", 0, 1'b0); ex("s5_addi", 2, 1'b0); chk();
        alu(5'd11, 5'd8, 5'd0, 1'b0); ex("s5_newest", 0, 1'b0); ex("s5_newest", 2, 1'b0); chk();
        lw(5'd8, 5'd1);            ex("s5_lw2", 0, 1'b0); ex("s5_lw2", 2, 1'b0); chk();
        lw(5'd9, 5'd8); flush = 1'b1;
                                   ex("s5_flush", 0, 1'b0); ex("s5_flush", 2, 1'b0); chk();
        flush = 1'b0;
        alu(5'd12, 5'd9, 5'd0, 1'b0); ex("s5_no_ins", 0, 1'b0); ex("s5_no_ins", 2, 1'b0); chk();
        idle();                    chk();

        // LOAD_USE_CYCLES=3: three bubbles, counter saturates at 3
        do_reset();
        lw(5'd5, 5'd1);            ex("s6_lw", 2, 1'b0, 0); chk();
        alu(5'd7, 5'd5, 5'd0, 1'b0);
                                   ex("s6_and1", 2, 1'b1, 0); chk();
                                   ex("s6_and2", 2, 1'b1, 1); chk();
                                   ex("s6_and3", 2, 1'b1, 2); chk();
                                   ex("s6_go", 2, 1'b0, 3); chk();
        idle();                    ex("s6_idle", 2, 1'b0, 3); chk();

        // Two sources on different entries: stall until the later one clears
        lw(5'd5, 5'd1);            ex("s6b_lw5", 2, 1'b0, 3); chk();
        lw(5'd6, 5'd1);            ex("s6b_lw6", 2, 1'b0, 3); chk();
        alu(5'd7, 5'd5, 5'd6, 1'b1);
                                   ex("s6b_st1", 2, 1'b1, 3); chk();
                                   ex("s6b_sat", 2, 1'b1, 3); chk();
                                   ex("s6b_st3", 2, 1'b1, 3); chk();
                                   ex("s6b_go", 2, 1'b0, 3); chk();
        idle();                    chk();

        // Asynchronous reset in the middle of a stall
        lw(5'd5, 5'd1);            ex("s6c_lw", 2, 1'b0, 3); chk();
        alu(5'd7, 5'd5, 5'd0, 1'b0);
                                   ex("s6c_st1", 2, 1'b1, 3); chk();
        #3;
        ex("s6c_st2", 2, 1'b1, 3); chk_now();
        rstn = 1'b0;
        #1;
        ex("s6c_rst", 2, 1'b0, 0, 0); chk_now();
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        ex("s6c_after", 2, 1'b0, 0, 0); chk();
        idle();                    chk();

        // Single-slot scoreboard: second writer finds no slot, overflow sticks
        do_reset();
        lw(5'd8, 5'd1);            ex("s7_lw", 3, 1'b0, -1, 0); chk();
        alu(5'd10, 5'd1, 5'd0, 1'b0); ex("s7_add", 3, 1'b0, -1, 0); chk();
        idle();                    ex("s7_ovf", 3, 1'b0, -1, 1); chk();
                                   ex("s7_sticky", 3, 1'b0, -1, 1); ex("s7_a_clean", 0, 1'b0, -1, 0); chk();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
